// File: rtl/vx_decode_ibuf.sv
// vx_decode_ibuf
// Per-channel instruction buffer that sits between decode and issue.
// Every issue channel has its own FIFO of DEPTH decoded instructions.
// The decoder pushes one instruction per cycle into the channel named by
// in_ch. Each channel presents its head entry to its own consumer.
//
// Configuration macro: DECODE_IBUF_BYPASS_EN
//   Defined:   an instruction sent to an empty channel whose consumer is
//              ready goes straight to that channel's outputs in the same
//              cycle. It is never stored.
//   Undefined: there is no combinational path from the input to the
//              outputs. A pushed entry becomes visible one cycle after it
//              is pushed.
//
// Ports
//   clk        in   clock; all state updates on its rising edge
//   resetn     in   asynchronous active-low reset
//   in_valid   in   decoded instruction present
//   in_ch      in   destination channel (values >= NUM_CHANNELS are dropped)
//   in_data    in   decoded instruction payload
//   in_ready   out  the channel addressed by in_ch can accept this cycle
//   out_valid  out  per-channel head entry valid
//   out_data   out  per-channel head payload, channel i at [i*DATAW +: DATAW]
//   out_ready  in   per-channel consumer ready
//   ibuf_pop   out  per-channel pop strobe (out_valid & out_ready)
//   count      out  per-channel occupancy 0..DEPTH, channel i at [i*CNT_W +: CNT_W]
module vx_decode_ibuf #(
    parameter int NUM_CHANNELS = 4,
    parameter int DEPTH        = 4,
    parameter int DATAW        = 64,
    localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          in_valid,
    input  logic [CH_W-1:0]               in_ch,
    input  logic [DATAW-1:0]              in_data,
    output logic                          in_ready,
    output logic [NUM_CHANNELS-1:0]       out_valid,
    output logic [NUM_CHANNELS*DATAW-1:0] out_data,
    input  logic [NUM_CHANNELS-1:0]       out_ready,
    output logic [NUM_CHANNELS-1:0]       ibuf_pop,
    output logic [NUM_CHANNELS*CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATAW-1:0] mem_r    [NUM_CHANNELS][DEPTH];
    logic [PTR_W-1:0] wr_ptr_r [NUM_CHANNELS];
    logic [PTR_W-1:0] rd_ptr_r [NUM_CHANNELS];
    logic [CNT_W-1:0] count_r  [NUM_CHANNELS];

    logic [NUM_CHANNELS-1:0] hit_s;
    logic [NUM_CHANNELS-1:0] full_s;
    logic [NUM_CHANNELS-1:0] empty_s;
    logic [NUM_CHANNELS-1:0] byp_s;
    logic [NUM_CHANNELS-1:0] push_s;
    logic [NUM_CHANNELS-1:0] pop_s;

    // Per-channel handshake decode and head-entry / occupancy output muxing.
    always_comb begin
        in_ready  = 1'b0;
        hit_s     = '0;
        full_s    = '0;
        empty_s   = '0;
        byp_s     = '0;
        push_s    = '0;
        pop_s     = '0;
        out_valid = '0;
        ibuf_pop  = '0;
        out_data  = '0;
        count     = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            // A channel index that matches no channel leaves in_ready low,
            // so an illegal in_ch is never accepted.
            hit_s[i]   = (in_ch == CH_W'(i));
            full_s[i]  = (count_r[i] == CNT_W'(DEPTH));
            empty_s[i] = (count_r[i] == {CNT_W{1'b0}});
            if (hit_s[i]) begin
                in_ready = ~full_s[i];
            end else begin
                in_ready = in_ready;
            end
`ifdef DECODE_IBUF_BYPASS_EN
            // Bypass is gated by resetn so that no pop strobe can appear
            // while the block is held in reset.
            byp_s[i] = resetn & in_valid & hit_s[i] & empty_s[i] & out_ready[i];
`else
            byp_s[i] = 1'b0;
`endif
            push_s[i]    = in_valid & hit_s[i] & ~full_s[i] & ~byp_s[i];
            pop_s[i]     = ~empty_s[i] & out_ready[i];
            out_valid[i] = ~empty_s[i] | byp_s[i];
            ibuf_pop[i]  = out_valid[i] & out_ready[i];
            out_data[i*DATAW +: DATAW] = byp_s[i] ? in_data : mem_r[i][rd_ptr_r[i]];
            count[i*CNT_W +: CNT_W]    = count_r[i];
        end
    end

    // Pointer and occupancy state per channel. When a push and a pop happen
    // together, both pointers advance and the count stays the same.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                wr_ptr_r[i] <= {PTR_W{1'b0}};
                rd_ptr_r[i] <= {PTR_W{1'b0}};
                count_r[i]  <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (push_s[i]) begin
                    wr_ptr_r[i] <= wr_ptr_r[i] + 1'b1;
                end else begin
                    wr_ptr_r[i] <= wr_ptr_r[i];
                end
                if (pop_s[i]) begin
                    rd_ptr_r[i] <= rd_ptr_r[i] + 1'b1;
                end else begin
                    rd_ptr_r[i] <= rd_ptr_r[i];
                end
                case ({push_s[i], pop_s[i]})
                    2'b10:   count_r[i] <= count_r[i] + 1'b1;
                    2'b01:   count_r[i] <= count_r[i] - 1'b1;
                    default: count_r[i] <= count_r[i];
                endcase
            end
        end
    end

    // Payload storage. It is left uncleared on reset because the counts
    // already mark every entry as empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (push_s[i]) begin
                mem_r[i][wr_ptr_r[i]] <= in_data;
            end else begin
                mem_r[i][wr_ptr_r[i]] <= mem_r[i][wr_ptr_r[i]];
            end
        end
    end

endmodule

// File: tb/tb_vx_decode_ibuf.sv
// tb_vx_decode_ibuf
// Self-checking bench for vx_decode_ibuf with 4 channels, depth 4 and
// 64-bit payloads. Each channel is modelled as a queue. Outputs are checked
// one time unit after the inputs change on the falling edge. The model is
// then advanced on the rising edge.
module tb_vx_decode_ibuf;

    localparam int NCH   = 4;
    localparam int DEPTH = 4;
    localparam int DATAW = 64;
    localparam int CNT_W = 3;

    logic                  clk;
    logic                  resetn;
    logic                  in_valid;
    logic [1:0]            in_ch;
    logic [DATAW-1:0]      in_data;
    logic                  in_ready;
    logic [NCH-1:0]        out_valid;
    logic [NCH*DATAW-1:0]  out_data;
    logic [NCH-1:0]        out_ready;
    logic [NCH-1:0]        ibuf_pop;
    logic [NCH*CNT_W-1:0]  count;

    logic [63:0] q [NCH][$];

    int n_tests;
    int n_fail;

    vx_decode_ibuf #(.NUM_CHANNELS(NCH), .DEPTH(DEPTH), .DATAW(DATAW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ch     (in_ch),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .ibuf_pop  (ibuf_pop),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, check the outputs against the queues, clock the edge, update the queues.
    task automatic step(input logic v, input logic [1:0] ch, input logic [63:0] d, input logic [3:0] ordy);
        logic           exp_rdy;
        logic           byp;
        logic [NCH-1:0] exp_ov;
        logic [63:0]    exp_d;
        in_valid  = v;
        in_ch     = ch;
        in_data   = d;
        out_ready = ordy;
        #1;
        exp_rdy = (q[ch].size() < DEPTH);
        byp     = 1'b0;
`ifdef DECODE_IBUF_BYPASS_EN
        byp = v && (q[ch].size() == 0) && ordy[ch];
`endif
        chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        for (int i = 0; i < NCH; i++) begin
            exp_ov[i] = (q[i].size() != 0) || (byp && (int'(ch) == i));
            chk($sformatf("out_valid[%0d]", i), {63'd0, out_valid[i]}, {63'd0, exp_ov[i]});
            chk($sformatf("ibuf_pop[%0d]", i), {63'd0, ibuf_pop[i]}, {63'd0, exp_ov[i] & ordy[i]});
            chk($sformatf("count[%0d]", i), {61'd0, count[i*CNT_W +: CNT_W]}, 64'(q[i].size()));
            if (exp_ov[i]) begin
                exp_d = (byp && (int'(ch) == i)) ? d : q[i][0];
                chk($sformatf("out_data[%0d]", i), out_data[i*DATAW +: DATAW], exp_d);
            end
        end
        @(posedge clk);
        for (int i = 0; i < NCH; i++) begin
            if ((q[i].size() != 0) && ordy[i]) begin
                void'(q[i].pop_front());
            end
        end
        if (v && exp_rdy && !byp) begin
            q[ch].push_back(d);
        end
        @(negedge clk);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_ch     = 2'd0;
        in_data   = 64'd0;
        out_ready = 4'h0;
        #2;
        chk("rst_count", {52'd0, count}, 64'd0);
        chk("rst_out_valid", {60'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Fill channel 2 while its consumer is stalled.
        for (int k = 0; k < 4; k++) step(1'b1, 2'd2, 64'h10 + 64'(k), 4'h0);
        chk("fill_count2", {61'd0, count[2*CNT_W +: CNT_W]}, 64'd4);
        step(1'b0, 2'd2, 64'h0, 4'h0);
        step(1'b0, 2'd0, 64'h0, 4'h0);
        // A full channel refuses a push even while its consumer pops.
        step(1'b1, 2'd2, 64'hEE, 4'b0100);
        for (int k = 0; k < 3; k++) step(1'b0, 2'd0, 64'h0, 4'b0100);
        chk("drain_count2", {61'd0, count[2*CNT_W +: CNT_W]}, 64'd0);
        chk("drain_valid2", {63'd0, out_valid[2]}, 64'd0);
        // An empty channel must not underflow.
        step(1'b0, 2'd0, 64'h0, 4'hF);

        // Channel 1 at count 2, then push and pop together across the pointer wrap.
        step(1'b1, 2'd1, 64'hA0, 4'h0);
        step(1'b1, 2'd1, 64'hA1, 4'h0);
        for (int k = 0; k < 7; k++) step(1'b1, 2'd1, 64'hAA + 64'(k), 4'b0010);
        chk("simul_count1", {61'd0, count[1*CNT_W +: CNT_W]}, 64'd2);
        step(1'b0, 2'd1, 64'h0, 4'b0010);
        step(1'b0, 2'd1, 64'h0, 4'b0010);

        // Push to empty channel 3 while its consumer is ready.
        step(1'b1, 2'd3, 64'h55, 4'b1000);
        step(1'b0, 2'd3, 64'h0, 4'b1000);

        // Reset asserted in the middle of a cycle while channel 0 holds 3 entries.
        for (int k = 0; k < 3; k++) step(1'b1, 2'd0, 64'h70 + 64'(k), 4'h0);
        in_valid  = 1'b0;
        in_ch     = 2'd0;
        out_ready = 4'hF;
        resetn    = 1'b0;
        #1;
        chk("midrst_count", {52'd0, count}, 64'd0);
        chk("midrst_out_valid", {60'd0, out_valid}, 64'd0);
        chk("midrst_ibuf_pop", {60'd0, ibuf_pop}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < NCH; i++) q[i].delete();
        #1;
        resetn = 1'b1;
        @(negedge clk);
        step(1'b1, 2'd0, 64'h99, 4'h0);
        step(1'b0, 2'd0, 64'h0, 4'h0);
        chk("postrst_head0", out_data[DATAW-1:0], 64'h99);
        step(1'b0, 2'd0, 64'h0, 4'h1);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 {$urandom, $urandom}, 4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vx_decode_ibuf.md
VX_DECODE_IBUF -- requirements
Module: VX_decode_ibuf

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4, number of issue channels (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, entries per channel; power of two, >=2.
REQ-003 SHALL have parameter DATAW, default 64, width of one decoded-instruction payload.
REQ-004 SHALL derive CH_W = max(1, log2(NUM_CHANNELS)) and CNT_W = log2(DEPTH)+1.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  clock; all state updates on its rising edge.
REQ-007 resetn  input  1  asynchronous active-low reset.
REQ-008 in_valid  input  1  decoded instruction present.
REQ-009 in_ch  input  CH_W  destination channel; values >= NUM_CHANNELS are illegal.
REQ-010 in_data  input  DATAW  decoded instruction payload.
REQ-011 in_ready  output  1  buffer accepts in_data this cycle.
REQ-012 out_valid  output  NUM_CHANNELS  per-channel head entry valid.
REQ-013 out_data  output  NUM_CHANNELS*DATAW  per-channel head payload; channel i at bits [i*DATAW +: DATAW].
REQ-014 out_ready  input  NUM_CHANNELS  per-channel consumer ready.
REQ-015 ibuf_pop  output  NUM_CHANNELS  per-channel pop strobe.
REQ-016 count  output  NUM_CHANNELS*CNT_W  per-channel occupancy, 0..DEPTH.

Function
REQ-017 Each channel SHALL be an independent FIFO of DEPTH entries with read/write pointers wrapping from DEPTH-1 to 0.
REQ-018 in_ready SHALL equal !full[in_ch], depending only on registered state, never on out_ready.
REQ-019 Push SHALL occur when in_valid && in_ready; payload is written at write pointer of channel in_ch.
REQ-020 out_valid[i] SHALL equal (count[i] != 0), plus bypass case of REQ-029.
REQ-021 out_data[i] SHALL present the entry at channel i read pointer; stable while out_valid[i] && !out_ready[i].
REQ-022 Pop SHALL occur when out_valid[i] && out_ready[i]; ibuf_pop[i] is asserted combinationally in that same cycle, low otherwise.
REQ-023 Push-only: count +1; pop-only: count -1; push and pop on same channel same cycle: count unchanged, both pointers advance.
REQ-024 Full channel (count == DEPTH): in_ready low for in_ch addressing it, even if out_ready high that cycle.
REQ-025 Empty channel: out_valid low, no pop, count stays 0 (no underflow).
REQ-026 Pushes to one channel SHALL NOT affect any other channel's state or outputs.
REQ-027 Latency without bypass: pushed entry visible on out_valid/out_data exactly 1 cycle after push edge.

Reset
REQ-028 On resetn low, immediately and independent of clk: all counts and pointers 0, out_valid all 0, ibuf_pop all 0, in_ready 1; entries discarded, including mid-stream; payload storage need not be cleared.

Configuration
REQ-029 Macro DECODE_IBUF_BYPASS_EN: when defined, if channel in_ch is empty and out_ready[in_ch] is high, in_valid SHALL drive out_valid[in_ch] and out_data[in_ch]=in_data combinationally in the same cycle, ibuf_pop[in_ch] pulses, count and pointers unchanged (zero latency); if empty but out_ready low, entry is stored normally.
REQ-030 When DECODE_IBUF_BYPASS_EN is undefined, no combinational path from in_valid/in_data to outputs; REQ-027 latency applies.

Verification
REQ-031 Fill: NUM_CHANNELS=4, DEPTH=4, push 4 entries 0x10..0x13 to ch2, out_ready=0 -> count[2]=4, in_ready=0 when in_ch=2, in_ready=1 when in_ch=0.
REQ-032 Drain order: after REQ-031, out_ready[2]=1 for 4 cycles -> out_data[2]=0x10,0x11,0x12,0x13, ibuf_pop[2]=1 each cycle, then count[2]=0, out_valid[2]=0.
REQ-033 Simultaneous: ch1 count=2, push 0xAA and pop same cycle -> count[1] stays 2; 6 further push+pop cycles wrap pointers, FIFO order preserved.
REQ-034 Bypass: empty ch3, out_ready[3]=1, push 0x55 -> with DECODE_IBUF_BYPASS_EN out_valid[3]=1, out_data[3]=0x55, ibuf_pop[3]=1 same cycle, count[3]=0; without it out_valid[3] rises next cycle.
REQ-035 Reset mid-op: ch0 count=3, deassert resetn between edges -> count all 0, out_valid=0, ibuf_pop=0 immediately; after release, first push to ch0 appears as sole entry.
